// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths.
// Optional build macro: UART_TX_TWO_STOP_EN selects two stop bits on TX.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Per-frame line configuration captured when a word is accepted
    typedef struct packed {
        logic                  par_en;
        logic                  par_typ;
        logic [PRESCALE_W-1:0] prescale;
    } uart_cfg_t;

    // A prescale of zero behaves as one cycle per bit
    function automatic logic [PRESCALE_W-1:0] prescale_eff(input logic [PRESCALE_W-1:0] p);
        return (p == '0) ? PRESCALE_W'(1) : p;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Edge counter (cycles within a bit) and bit counter for the UART transmitter.
// Optional build macro: none used here (UART_TX_TWO_STOP_EN is handled by the top).
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic [CNT_W-1:0]      bit_cnt
);

    logic [PRESCALE_W-1:0] edge_cnt;

    // Last cycle of the current bit
    assign bit_done = enable && (edge_cnt == (prescale - PRESCALE_W'(1)));

    // Edge counter wraps at each bit boundary; bit counter advances once per bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + CNT_W'(1);
        end else if (enable) begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop.
// Optional build macro: UART_TX_TWO_STOP_EN (two stop bits per frame).
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  data_accept
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q;
    uart_cfg_t               cfg_q;
    logic                    tx_d;
    logic                    bit_done;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        idx_d;
    logic                    stop_last_c;
    logic                    accept_c;
    logic                    par_bit_c;
    logic                    timer_en;
    logic                    timer_clr;

    // Bit timing for the frame in flight
    uart_tx_bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (timer_en),
        .clear    (timer_clr),
        .prescale (cfg_q.prescale),
        .bit_done (bit_done),
        .bit_cnt  (bit_cnt)
    );

    assign timer_en    = (state_q != IDLE);
    assign timer_clr   = (state_d != state_q);
    assign stop_last_c = (state_q == STOP) && bit_done && (bit_cnt == CNT_W'(STOP_BITS - 1));
    assign accept_c    = DATA_VALID && ((state_q == IDLE) || stop_last_c);
    assign data_accept = accept_c && !RST;
    assign par_bit_c   = (^data_q) ^ cfg_q.par_typ;

    // Next state and next line level; TX_OUT is registered so it tracks state_d
    always_comb begin
        state_d = state_q;
        tx_d    = LINE_IDLE;
        idx_d   = '0;

        case (state_q)
            IDLE:    if (accept_c) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done && (bit_cnt == CNT_W'(DATA_WIDTH - 1))) begin
                    state_d = cfg_q.par_en ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_done) state_d = STOP;
            STOP:    if (stop_last_c) state_d = accept_c ? START : IDLE;
            default: state_d = IDLE;
        endcase

        // Data bit shown in the coming cycle
        if (state_q == DATA) begin
            idx_d = bit_done ? (bit_cnt + CNT_W'(1)) : bit_cnt;
        end

        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = par_bit_c;
            default: tx_d = LINE_IDLE;
        endcase
    end

    // State, line and busy registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            TX_OUT  <= LINE_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Per-frame capture of the word and line settings
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            cfg_q  <= '0;
        end else if (accept_c) begin
            data_q         <= P_DATA;
            cfg_q.par_en   <= PAR_EN;
            cfg_q.par_typ  <= PAR_TYP;
            cfg_q.prescale <= prescale_eff(prescale);
        end
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- UART transmitter: the TX counterpart to the oversampled RX path.
- Accepts a parallel word and serialises one frame on TX_OUT: start bit, data LSB-first, optional parity bit, stop bit.
- Each bit is held for `prescale` CLK cycles, so TX shares the RX oversampling clock and prescale setting.
- Sits between the system-side TX FIFO/synchroniser and the UART pad.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  in  1  single clock, the UART oversampling clock shared with RX.
- RST  in  1  asynchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  word to transmit.
- DATA_VALID  in  1  request: P_DATA is valid this cycle.
- PAR_EN  in  1  1 = parity bit inserted.
- PAR_TYP  in  1  0 = even, 1 = odd.
- prescale  in  6  CLK cycles per bit; legal values 1..63, and 0 is treated as 1.
- TX_OUT  out  1  serial line, idle high.
- busy  out  1  high while a frame is in flight.
- data_accept  out  1  one-cycle pulse when P_DATA is latched.

Behaviour:
- Reset values (async, RST=1): TX_OUT=1, busy=0, data_accept=0, FSM=IDLE, all counters 0, latched registers 0.
- Reset asserted mid-frame: the frame is abandoned immediately and TX_OUT returns to 1 in the same cycle (asynchronous).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Per-frame latching: on acceptance, P_DATA, PAR_EN, PAR_TYP and prescale (0 mapped to 1) are latched. Input changes during the frame have no effect.
- Parity is computed from the latched data: even gives XOR of the data bits; odd gives its inverse.
- Acceptance: DATA_VALID=1 at a posedge while FSM=IDLE, or in the last cycle of STOP.
  - data_accept pulses for that same cycle.
  - From the next cycle: FSM=START, TX_OUT=0, busy=1.
- Bit timing: an edge counter counts 0..P-1, where P is the latched prescale. Each bit drives TX_OUT for exactly P cycles, and the counter wraps to 0 at each bit boundary.
- DATA state: a bit counter 0..DATA_WIDTH-1 selects data[bit_cnt]. The FSM leaves DATA after bit DATA_WIDTH-1 completes.
- Transitions:
  - START to DATA after P cycles.
  - DATA to PARITY if PAR_EN=1, otherwise DATA to STOP.
  - PARITY to STOP after P cycles.
  - STOP, after P cycles, goes to START if DATA_VALID was accepted in the last STOP cycle, otherwise to IDLE.
- Back-to-back frames: no idle gap between them; busy stays 1 throughout.
- End of frame without a new request: busy=0 and TX_OUT=1 from the cycle after the last STOP cycle.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × P cycles, counted from the first START cycle.
- DATA_VALID while busy, outside the last STOP cycle, is ignored with no data_accept. The upstream block must hold DATA_VALID until data_accept is seen.
- TX_OUT is driven from a register (glitch-free). Output latency is 1 cycle from the accept edge.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2×P cycles (two stop bits), and frame length is (3 + DATA_WIDTH + PAR_EN) × P. Back-to-back acceptance moves to the last cycle of the second stop bit.
- Undefined: one stop bit, exactly as described above.

Decomposition:
- Shared package (uart_pkg):
  - FSM state typedef with encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - PRESCALE_W=6.
  - Line-level constants LINE_IDLE=1 and START_BIT=0.
  - Reused by the RX side.
- Sub-module uart_tx_bit_timer holds the edge counter and bit counter.
  - Inputs: enable, latched prescale, clear.
  - Outputs: bit_done (last cycle of a bit) and bit_cnt.
  - This is the TX analogue of the RX edge/bit counting.
- Top-level module holds the FSM, the latching registers, the parity generator and the TX_OUT mux.

Test Plan:
- Reset idle: RST pulse, no DATA_VALID for 100 cycles -> TX_OUT=1, busy=0, data_accept never asserted.
- Even parity, P=8: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> data_accept for 1 cycle; 88-cycle frame; line sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; busy falls after cycle 88.
- Odd parity, no parity, P=16: 0xA5 with PAR_TYP=1 -> parity bit 1, 176-cycle frame. 0xFF with PAR_EN=0 -> 160-cycle frame, no parity slot.
- Back-to-back, P=8: DATA_VALID held with 0x3C then 0xC3 -> second START begins the cycle after the first STOP ends; busy stays 1; two data_accept pulses 80 cycles apart (PAR_EN=0).
- Input stability and prescale 0: change P_DATA/prescale/PAR_TYP mid-frame -> transmitted frame is unchanged. prescale=0 -> each bit lasts 1 cycle (10-cycle frame, PAR_EN=0).
- Mid-frame reset and UART_TX_TWO_STOP_EN: assert RST during DATA bit 3 -> TX_OUT=1 and busy=0 immediately, next DATA_VALID starts a clean frame. With the macro defined, P=8, PAR_EN=0 -> stop high for 16 cycles, 88-cycle frame.
